ring_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one resource among N requesters using a one-hot rotating priority pointer, the same one-hot ring encoding as the team's 4-bit ring counter. It sits between the requesters and the shared resource. It issues a registered one-hot grant, holds that grant until the owner releases it or a hold limit expires, then advances priority to the requester after the last winner.

---
 rtl/ring_rr_arbiter.sv | 118 +++++++++++
 tb/tb_ring_rr_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter for N requesters with a one-hot rotating priority pointer.
// Grants are registered and held until the owner releases or the hold limit forces release.
module ring_rr_arbiter #(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 16,
    localparam int IDW      = $clog2(N),
    localparam int HW       = $clog2(MAX_HOLD)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   done,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic [N-1:0]   ptr,
    output logic           timeout,
    output logic           fsm_state
);

    // Handshake: a requester owns the resource while its gnt bit is high; it gives it
    // back by pulsing its done bit or dropping its req bit, sampled on the rising edge.
    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nx;
    logic [N-1:0]    gnt_nx, ptr_nx;
    logic            valid_nx, tmo_nx;
    logic [IDW-1:0]  id_nx;
    logic [HW-1:0]   hold, hold_nx;

    logic [IDW-1:0]  ptr_idx;
    logic [IDW-1:0]  cand;
    logic [IDW-1:0]  pick_id;
    logic            pick_found;
    logic            normal_rel;
    logic            limit_hit;

    assign fsm_state  = (state == GRANT);
    assign normal_rel = done[gnt_id] | ~req[gnt_id];
    assign limit_hit  = (hold == HW'(MAX_HOLD - 1));

    always_comb begin
        ptr_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (ptr[i]) ptr_idx = IDW'(i);
        end
    end

    // Search starts at the pointer position and wraps from N-1 back to 0.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int i = 0; i < N; i++) begin
            cand = IDW'((int'(ptr_idx) + i) % N);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        valid_nx = gnt_valid;
        id_nx    = gnt_id;
        ptr_nx   = ptr;
        hold_nx  = hold;
        tmo_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    gnt_nx   = {{(N-1){1'b0}}, 1'b1} << pick_id;
                    valid_nx = 1'b1;
                    id_nx    = pick_id;
                    hold_nx  = '0;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                hold_nx = hold + 1'b1;
                if (normal_rel || limit_hit) begin
                    gnt_nx   = '0;
                    valid_nx = 1'b0;
                    id_nx    = '0;
                    ptr_nx   = {gnt[N-2:0], gnt[N-1]};
                    hold_nx  = '0;
                    // A normal release on the limit cycle still counts as normal.
                    tmo_nx   = ~normal_rel;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            ptr       <= {{(N-1){1'b0}}, 1'b1};
            hold      <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nx;
            gnt       <= gnt_nx;
            gnt_valid <= valid_nx;
            gnt_id    <= id_nx;
            ptr       <= ptr_nx;
            hold      <= hold_nx;
            timeout   <= tmo_nx;
        end
    end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed bench for ring_rr_arbiter (N=4, MAX_HOLD=4): the driver queues one record per
// expected grant; the monitor builds a record whenever a grant ends and compares it.
module tb_ring_rr_arbiter;
    localparam int N  = 4;
    localparam int MH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_id;
    logic [N-1:0] ptr;
    logic         timeout;
    logic         fsm_state;

    always #5 clk = ~clk;

    ring_rr_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .ptr       (ptr),
        .timeout   (timeout),
        .fsm_state (fsm_state)
    );

    // One record per completed grant; gap = idle cycles before it (31 = not checked).
    typedef struct packed {
        logic [3:0] g;
        logic [1:0] id;
        logic [4:0] len;
        logic [4:0] gap;
        logic [3:0] p;
        logic       t;
    } rec_t;

    localparam int DC = 31;

    logic [20:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [20:0] mk(input logic [3:0] g, input logic [1:0] id, input int len,
                                       input int gap, input logic [3:0] p, input logic t);
        rec_t r;
        r.g   = g;
        r.id  = id;
        r.len = 5'(len);
        r.gap = 5'(gap);
        r.p   = p;
        r.t   = t;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string tag);
        int k;
        k = 0;
        while (!gnt_valid && k < 40) begin
            tick();
            k++;
        end
        n_cmp++;
        if (gnt_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s: gnt_valid=%b after 40 cycles, required 1", tag, gnt_valid);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    logic       rst_prev = 1'b0;
    logic       prev_valid = 1'b0;
    int         gap = 0;
    int         len = 0;
    int         s_gap = 0;
    logic [3:0] s_g = '0;
    logic [1:0] s_id = '0;
    rec_t       act, expd;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_prev) begin
                n_cmp++;
                if ({gnt, gnt_valid, gnt_id, ptr, timeout, fsm_state} !== {4'b0000, 1'b0, 2'b00, 4'b0001, 1'b0, 1'b0}) begin
                    n_err++;
                    $display("FAIL reset_state: gnt=%b valid=%b id=%0d ptr=%b timeout=%b state=%b, required 0000 0 0 0001 0 0",
                             gnt, gnt_valid, gnt_id, ptr, timeout, fsm_state);
                end
            end
            if (prev_valid && !gnt_valid) begin
                act = mk(s_g, s_id, len, s_gap, ptr, timeout);
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_grant: gnt=%b id=%0d len=%0d, required no grant", act.g, act.id, act.len);
                end else begin
                    expd = exp_q.pop_front();
                    if (expd.gap == 5'(DC)) act.gap = 5'(DC);
                    if (act !== expd) begin
                        n_err++;
                        $display("FAIL grant_end: got gnt=%b id=%0d len=%0d gap=%0d ptr=%b timeout=%b, required gnt=%b id=%0d len=%0d gap=%0d ptr=%b timeout=%b",
                                 act.g, act.id, act.len, act.gap, act.p, act.t,
                                 expd.g, expd.id, expd.len, expd.gap, expd.p, expd.t);
                    end
                end
            end else begin
                n_cmp++;
                if (timeout !== 1'b0) begin
                    n_err++;
                    $display("FAIL stray_timeout: timeout=%b gnt=%b, required 0", timeout, gnt);
                end
            end
            if (rst_prev) gap = 0;
            else if (!gnt_valid) begin
                if (prev_valid) gap = 1;
                else if (gap < 30) gap++;
            end
            if (gnt_valid && !prev_valid) begin
                s_g   = gnt;
                s_id  = gnt_id;
                s_gap = gap;
                len   = 0;
            end
            if (gnt_valid) len++;
            prev_valid = gnt_valid;
            rst_prev   = rst;
        end
    end

    initial begin
        int k;
        rst  = 1'b1;
        req  = 4'b1111;
        done = 4'b0000;

        // Reset held two cycles with all requesting, then first grant one edge later.
        exp_q.push_back(mk(4'b0001, 2'd0, 1, 0, 4'b0010, 1'b0));
        tick();
        tick();
        rst = 1'b0;
        wait_grant("reset_release");
        done = 4'b0001;
        req  = 4'b0000;
        tick();
        done = 4'b0000;
        repeat (3) tick();

        // Single requester: three-cycle grant, one idle cycle, re-grant.
        exp_q.push_back(mk(4'b0100, 2'd2, 3, DC, 4'b1000, 1'b0));
        exp_q.push_back(mk(4'b0100, 2'd2, 1, 1, 4'b1000, 1'b0));
        req = 4'b0100;
        wait_grant("single_1");
        tick();
        tick();
        done = 4'b0100;
        tick();
        done = 4'b0000;
        wait_grant("single_2");
        req = 4'b0000;
        tick();
        repeat (3) tick();

        // Rotation with everyone requesting from a fresh pointer.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        exp_q.push_back(mk(4'b0001, 2'd0, 1, 0, 4'b0010, 1'b0));
        exp_q.push_back(mk(4'b0010, 2'd1, 1, 1, 4'b0100, 1'b0));
        exp_q.push_back(mk(4'b0100, 2'd2, 1, 1, 4'b1000, 1'b0));
        exp_q.push_back(mk(4'b1000, 2'd3, 1, 1, 4'b0001, 1'b0));
        exp_q.push_back(mk(4'b0001, 2'd0, 1, 1, 4'b0010, 1'b0));
        for (int i = 0; i < 5; i++) begin
            wait_grant("rotation");
            done = 4'b0001 << (i % 4);
            if (i == 4) req = 4'b0000;
            tick();
            done = 4'b0000;
        end
        repeat (3) tick();

        // Forced release after MAX_HOLD cycles, twice.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0011;
        exp_q.push_back(mk(4'b0001, 2'd0, 4, 0, 4'b0010, 1'b1));
        exp_q.push_back(mk(4'b0010, 2'd1, 4, 1, 4'b0100, 1'b1));
        wait_grant("timeout_1");
        repeat (4) tick();
        wait_grant("timeout_2");
        repeat (4) tick();
        req = 4'b0000;
        repeat (3) tick();

        // Non-owner done bits ignored; release on request drop.
        exp_q.push_back(mk(4'b0010, 2'd1, 3, DC, 4'b0100, 1'b0));
        req = 4'b0010;
        wait_grant("ignored_done");
        done = 4'b1101;
        tick();
        tick();
        done = 4'b0000;
        req  = 4'b0000;
        tick();
        repeat (2) tick();

        // done on the limit cycle: normal release, no timeout.
        exp_q.push_back(mk(4'b0001, 2'd0, 4, DC, 4'b0010, 1'b0));
        req = 4'b0001;
        wait_grant("limit_coincide");
        repeat (3) tick();
        done = 4'b0001;
        req  = 4'b0000;
        tick();
        done = 4'b0000;
        repeat (2) tick();

        // Reset on the second cycle of a grant to requester 3.
        exp_q.push_back(mk(4'b1000, 2'd3, 2, DC, 4'b0001, 1'b0));
        exp_q.push_back(mk(4'b0001, 2'd0, 1, 0, 4'b0010, 1'b0));
        req = 4'b1000;
        wait_grant("mid_reset_1");
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1001;
        wait_grant("mid_reset_2");
        done = 4'b0001;
        req  = 4'b0000;
        tick();
        done = 4'b0000;
        repeat (3) tick();

        // Sparse requests: search skips idle ports and wraps past N-1.
        exp_q.push_back(mk(4'b0100, 2'd2, 1, DC, 4'b1000, 1'b0));
        exp_q.push_back(mk(4'b0001, 2'd0, 1, 1, 4'b0010, 1'b0));
        req = 4'b0101;
        wait_grant("sparse_1");
        done = 4'b0100;
        tick();
        done = 4'b0000;
        wait_grant("sparse_2");
        done = 4'b0001;
        req  = 4'b0000;
        tick();
        done = 4'b0000;
        repeat (2) tick();

        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            tick();
            k++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_grants: %0d records left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
